// File: rtl/ula_seq.sv
// Sequential ALU stage: falling-edge registered result/flags with a one-cycle done pulse.
// Optional shift-add unsigned multiply on opcode 12 when ULA_MUL_EN is defined.
module ula_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MUL_STEPS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err,
  output logic             busy,
  output logic             done
);

  if (WIDTH != 8 || MUL_STEPS != WIDTH) begin : g_bad_cfg
    $error("ula_seq supports only WIDTH = MUL_STEPS = 8");
  end

  localparam logic [3:0] OpAdd = 4'd0,  OpSub = 4'd1,  OpAnd = 4'd2,  OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4,  OpNot = 4'd5,  OpShl = 4'd6,  OpShr = 4'd7;
  localparam logic [3:0] OpInc = 4'd8,  OpDec = 4'd9,  OpPass = 4'd10, OpCmp = 4'd11;
  localparam logic [3:0] OpMul = 4'd12;

  logic [WIDTH:0]   sum9, diff9;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err, alu_wr;
  logic             idle;

  // alu_res doubles as the flag source; for CMP it is the difference but is not written back.
  always_comb begin
    sum9    = {1'b0, a} + {1'b0, b};
    diff9   = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    alu_wr  = 1'b1;
    case (op)
      OpAdd: begin
        alu_res = sum9[WIDTH-1:0];
        alu_c   = sum9[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum9[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub, OpCmp: begin
        alu_res = diff9[WIDTH-1:0];
        alu_c   = diff9[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff9[WIDTH-1] != a[WIDTH-1]);
        alu_wr  = (op != OpCmp);
      end
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpXor:  alu_res = a ^ b;
      OpNot:  alu_res = ~a;
      OpShl: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OpShr: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OpInc: begin
        alu_res = a + 1'b1;
        alu_c   = (a == {WIDTH{1'b1}});
        alu_v   = (a == {1'b0, {(WIDTH-1){1'b1}}});
      end
      OpDec: begin
        alu_res = a - 1'b1;
        alu_c   = (a == '0);
        alu_v   = (a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OpPass: alu_res = b;
`ifdef ULA_MUL_EN
      OpMul: ;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ULA_MUL_EN
  localparam int unsigned CntW = $clog2(MUL_STEPS);
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_STEPS - 1);

  typedef enum logic [0:0] {StIdle, StMulRun} state_t;
  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CntW-1:0]    cnt;
  logic               mul_last;

  always_ff @(negedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    acc_nxt  = acc + (mplier[0] ? mcand : '0);
    mul_last = (state_q == StMulRun) && (cnt == CntLast);
    case (state_q)
      StIdle:   if (start && op == OpMul) state_d = StMulRun;
      StMulRun: if (mul_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign idle = (state_q == StIdle);
  assign busy = (state_q == StMulRun);
`else
  assign idle = 1'b1;
  assign busy = 1'b0;
`endif

  always_ff @(negedge clock) begin
    if (reset) begin
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
`ifdef ULA_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ULA_MUL_EN
      if (idle && start && op == OpMul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else if (idle && start) begin
`else
      if (idle && start) begin
`endif
        if (alu_wr) begin
          result    <= alu_res;
          result_hi <= '0;
        end
        flag_z <= (alu_res == '0);
        flag_n <= alu_res[WIDTH-1];
        flag_c <= alu_c;
        flag_v <= alu_v;
        err    <= alu_err;
        done   <= 1'b1;
      end
`ifdef ULA_MUL_EN
      if (state_q == StMulRun) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          result    <= acc_nxt[WIDTH-1:0];
          result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
          flag_z    <= (acc_nxt == '0);
          flag_n    <= acc_nxt[2*WIDTH-1];
          flag_c    <= |acc_nxt[2*WIDTH-1:WIDTH];
          flag_v    <= |acc_nxt[2*WIDTH-1:WIDTH];
          err       <= 1'b0;
          done      <= 1'b1;
        end
      end
`endif
    end
  end

endmodule
